// File: rtl/seq_slice_adder.sv
`default_nettype none
// =============================================================================
// seq_slice_adder: WIDTH-bit adder built from one 4-bit ripple slice reused
// over WIDTH/4 cycles. Define SEQ_SLICE_ADDER_OVF_EN to add the ovf output.
// Revision: 1.0
// =============================================================================
module seq_slice_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
`ifdef SEQ_SLICE_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SEQ_SLICE_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [CNT_W+1:0] nib_base;
  logic [3:0]       a_nib, b_nib, slice_t, slice_s;
  logic [4:0]       slice_c;

  // Shared 4-bit ripple slice; slice_c[3] is the carry into the slice MSB.
  always_comb begin
    nib_base   = {cnt_q, 2'b00};
    a_nib      = a_q[nib_base +: 4];
    b_nib      = b_q[nib_base +: 4];
    slice_t    = '0;
    slice_s    = '0;
    slice_c    = '0;
    slice_c[0] = carry_q;
    for (int i = 0; i < 4; i++) begin
      slice_t[i]   = a_nib[i] ^ b_nib[i];
      slice_s[i]   = slice_t[i] ^ slice_c[i];
      slice_c[i+1] = (a_nib[i] & b_nib[i]) | (slice_t[i] & slice_c[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SEQ_SLICE_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in1;
          b_d     = in2;
          carry_d = carry_in;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[nib_base +: 4] = slice_s;
        carry_d              = slice_c[4];
        if (cnt_q == LAST_CNT) begin
          cout_d  = slice_c[4];
`ifdef SEQ_SLICE_ADDER_OVF_EN
          ovf_d   = slice_c[3] ^ slice_c[4];
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SEQ_SLICE_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SEQ_SLICE_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
`ifdef SEQ_SLICE_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
`default_nettype wire
